pipe_mem_ctrl: RTL
==================

Name: pipe_mem_ctrl

Overview:
- Controller for the EX/MEM pipeline register and the MEM stage it feeds.
- Sequences each load/store in MEM against a variable-latency data memory using a req/ack handshake.
- Stalls all upstream pipe registers (IF..EX/MEM) while an access is outstanding.
- Resolves branch, jump and jump-register redirects when the instruction leaves MEM, driving PC-source select and IF/ID and ID/EX flush.

Parameters:
TIMEOUT, 255, ACCESS cycles without dmem_ack before entering ERR
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
mem_valid  in  1  EX/MEM holds a valid (non-bubble) instruction
mem_memwrite  in  1  store in MEM
mem_memtoreg  in  1  load in MEM
mem_branch  in  1  conditional branch in MEM
mem_zero  in  1  ALU zero flag for branch
mem_jump  in  1  direct jump in MEM
mem_jumptoreg  in  1  register jump in MEM
mem_aluout  in  32  effective address
mem_memwritedata  in  32  store data
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  write enable, valid with dmem_req
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_wdata  out  32  store data
dmem_ack  in  1  access complete; rdata valid same cycle
dmem_rdata  in  32  load data
ldata  out  32  captured load data for MEM/WB
ldata_valid  out  1  one-cycle pulse when ldata updates
stall  out  1  hold all upstream pipe registers and PC
flush  out  1  clear IF/ID and ID/EX
pcsrc  out  2  0 = pc+4, 1 = branch, 2 = jump, 3 = jumptoreg
busy_err  out  1  sticky timeout error

Behaviour:
- Reset: sampled on rising clk.
  - While reset=0, state <- IDLE; cnt, ldata, busy_err, ldata_valid <- 0.
  - All outputs are forced to 0 combinationally during reset-low cycles.
- acc = mem_valid & (mem_memwrite | mem_memtoreg).
- States: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - stall = acc; dmem_req = 0.
  - If acc: latch we = mem_memwrite, addr = {mem_aluout[31:2],2'b00} and wdata, clear cnt, go ACCESS.
- ACCESS:
  - dmem_req = 1, stall = 1; dmem_we/addr/wdata come from the latched registers and are stable for the whole request.
  - On dmem_ack: ldata <- dmem_rdata if load (unchanged on store), go DONE.
  - Otherwise cnt <- cnt+1; at cnt == TIMEOUT-1 without ack, go ERR and set busy_err.
  - Ack on the same cycle as the timeout boundary wins and goes DONE.
- DONE:
  - stall = 0, dmem_req = 0, ldata_valid = 1 for loads only.
  - Pipeline advances at the end of this cycle.
  - Next state is always IDLE, so the completed instruction is never re-issued.
- ERR:
  - stall = 1, dmem_req = 0, busy_err = 1.
  - Left only by reset.
- Minimum access latency is 2 cycles (req, ack in the first ACCESS cycle) plus the DONE cycle, so a load stalls for 2 cycles best case.
- dmem_ack outside ACCESS is ignored.
- Redirect logic:
  - taken = mem_valid & ((mem_branch & mem_zero) | mem_jump | mem_jumptoreg).
  - Priority is jumptoreg > jump > branch.
  - pcsrc and flush are valid only when stall = 0; otherwise pcsrc = 0 and flush = 0.
  - flush = taken & ~stall.
- Non-access, non-redirect instructions: stall = 0, pcsrc = 0, no state change.
- Reset mid-ACCESS: dmem_req drops in the reset cycle; the pending ack is discarded.

Test Plan:
- Load at aluout=0x0000_1006, ack after 3 ACCESS cycles, rdata=0xDEAD_BEEF -> dmem_addr=0x0000_1004, dmem_we=0, stall high for 4 cycles, ldata=0xDEADBEEF with ldata_valid=1 in DONE, then IDLE.
- Store with wdata=0x1234_5678, ack in the first ACCESS cycle -> dmem_we=1, dmem_wdata stable, stall high for exactly 2 cycles, ldata_valid never asserts, ldata unchanged.
- mem_branch=1, mem_zero=1 -> pcsrc=1, flush=1 the same cycle. Repeat with mem_zero=0 -> pcsrc=0, flush=0. With jump+jumptoreg both set -> pcsrc=3.
- Load with no ack (TIMEOUT=4) -> after 4 ACCESS cycles state ERR, busy_err=1, stall=1, dmem_req=0. A late ack has no effect; only reset clears the error.
- reset=0 asserted in the second ACCESS cycle -> next cycle dmem_req=0, stall=0, busy_err=0. Ack arriving after reset releases is ignored.
- Back-to-back loads at 0x10 and 0x14, each acked in one cycle -> two distinct requests with a one-cycle DONE gap, two ldata_valid pulses, no duplicate request for the first load.

Source files
------------

// File: rtl/pipe_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_ctrl
// Brief    : EX/MEM and MEM-stage controller. It sequences loads and stores
//            against a req/ack data memory, stalls upstream while an access is
//            in flight, and resolves control-flow redirects leaving MEM.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_memwrite,
    input  logic        mem_memtoreg,
    input  logic        mem_branch,
    input  logic        mem_zero,
    input  logic        mem_jump,
    input  logic        mem_jumptoreg,
    input  logic [31:0] mem_aluout,
    input  logic [31:0] mem_memwritedata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ldata,
    output logic        ldata_valid,
    output logic        stall,
    output logic        flush,
    output logic [1:0]  pcsrc,
    output logic        busy_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;
    localparam logic [1:0] c_ERR    = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_ldata;
    logic             r_busy_err;

    logic             w_acc;
    logic             w_taken;
    logic             w_stall;
    logic             w_unused_addr_bits;

    assign w_acc   = mem_valid & (mem_memwrite | mem_memtoreg);
    assign w_taken = mem_valid & ((mem_branch & mem_zero) | mem_jump | mem_jumptoreg);

    // Byte-offset bits never reach memory; the interface is word addressed.
    assign w_unused_addr_bits = &{1'b0, mem_aluout[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_acc) w_state_nxt = c_ACCESS;
            c_ACCESS: begin
                // An ack on the timeout boundary still completes the access.
                if (dmem_ack)                 w_state_nxt = c_DONE;
                else if (r_cnt == c_CNT_LAST) w_state_nxt = c_ERR;
            end
            c_DONE:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ldata    <= '0;
            r_busy_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_acc) begin
                        r_we    <= mem_memwrite;
                        r_addr  <= {mem_aluout[31:2], 2'b00};
                        r_wdata <= mem_memwritedata;
                        r_cnt   <= '0;
                    end
                end
                c_ACCESS: begin
                    if (dmem_ack) begin
                        if (!r_we) r_ldata <= dmem_rdata;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_busy_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_stall     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        ldata       = '0;
        ldata_valid = 1'b0;
        busy_err    = 1'b0;
        flush       = 1'b0;
        pcsrc       = 2'd0;
        if (reset) begin
            dmem_addr  = r_addr;
            dmem_wdata = r_wdata;
            ldata      = r_ldata;
            busy_err   = r_busy_err;
            case (r_state)
                c_IDLE:   w_stall = w_acc;
                c_ACCESS: begin
                    w_stall  = 1'b1;
                    dmem_req = 1'b1;
                    dmem_we  = r_we;
                end
                c_DONE:   ldata_valid = ~r_we;
                default:  w_stall = 1'b1;
            endcase
            if (w_taken && !w_stall) begin
                flush = 1'b1;
                if (mem_jumptoreg)  pcsrc = 2'd3;
                else if (mem_jump)  pcsrc = 2'd2;
                else                pcsrc = 2'd1;
            end
        end
    end

    assign stall = w_stall;

endmodule
`default_nettype wire
